vga_timing_generator: RTL and testbench

//  Raster timing source for the VGA path. Runs horizontal and vertical position counters and

---
 rtl/vga_timing_generator.sv | 104 ++++++++++
 tb/tb_vga_timing_generator.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// Raster timing source: h/v position counters with registered sync, draw-enable and scanline decode.
// Optional o_FRAME_START pulse is built only when VGA_TIMING_FRAME_START_EN is defined.
module vga_timing_generator #(
    parameter int   p_H_VISIBLE_AREA  = 640,
    parameter int   p_H_FRONT_PORCH   = 16,
    parameter int   p_H_SYNC_PULSE    = 96,
    parameter int   p_H_BACK_PORCH    = 48,
    parameter int   p_V_VISIBLE_AREA  = 480,
    parameter int   p_V_FRONT_PORCH   = 10,
    parameter int   p_V_SYNC_PULSE    = 2,
    parameter int   p_V_BACK_PORCH    = 33,
    parameter logic p_H_SYNC_POLARITY = 1'b0,
    parameter logic p_V_SYNC_POLARITY = 1'b0
) (
    input  logic                                i_CLK,
    input  logic                                i_RESET,
    input  logic                                i_ENABLE,
    output logic                                o_HSYNC,
    output logic                                o_VSYNC,
    output logic                                o_DRAW_ENABLE,
    output logic [$clog2(p_H_VISIBLE_AREA)-1:0] o_SCANLINE_X,
    output logic [$clog2(p_V_VISIBLE_AREA)-1:0] o_SCANLINE_Y
`ifdef VGA_TIMING_FRAME_START_EN
    ,
    output logic                                o_FRAME_START
`endif
);

    localparam int H_TOTAL = p_H_VISIBLE_AREA + p_H_FRONT_PORCH + p_H_SYNC_PULSE + p_H_BACK_PORCH;
    localparam int V_TOTAL = p_V_VISIBLE_AREA + p_V_FRONT_PORCH + p_V_SYNC_PULSE + p_V_BACK_PORCH;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(p_H_VISIBLE_AREA);
    localparam int YW = $clog2(p_V_VISIBLE_AREA);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(p_H_VISIBLE_AREA);
    localparam logic [HW-1:0] H_SYNC_S = HW'(p_H_VISIBLE_AREA + p_H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC_E = HW'(p_H_VISIBLE_AREA + p_H_FRONT_PORCH + p_H_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(p_V_VISIBLE_AREA);
    localparam logic [VW-1:0] V_SYNC_S = VW'(p_V_VISIBLE_AREA + p_V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC_E = VW'(p_V_VISIBLE_AREA + p_V_FRONT_PORCH + p_V_SYNC_PULSE);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_vis;
    logic          v_vis;
    logic          h_sync_act;
    logic          v_sync_act;

    // Next position: the horizontal wrap is the only point where the line counter moves.
    always_comb begin
        h_nxt = h_cnt + HW'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end
    end

    // Outputs are decoded from the next position so they describe the counters with no lag.
    always_comb begin
        h_vis      = (h_nxt < H_VIS);
        v_vis      = (v_nxt < V_VIS);
        h_sync_act = (h_nxt >= H_SYNC_S) && (h_nxt < H_SYNC_E);
        v_sync_act = (v_nxt >= V_SYNC_S) && (v_nxt < V_SYNC_E);
    end

    // Reset parks the raster on the last back-porch position so the first tick lands on (0,0).
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            o_DRAW_ENABLE <= 1'b0;
            o_SCANLINE_X  <= '0;
            o_SCANLINE_Y  <= '0;
            o_HSYNC       <= ~p_H_SYNC_POLARITY;
            o_VSYNC       <= ~p_V_SYNC_POLARITY;
        end else if (i_ENABLE) begin
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            o_DRAW_ENABLE <= h_vis && v_vis;
            o_SCANLINE_X  <= h_vis ? h_nxt[XW-1:0] : '0;
            o_SCANLINE_Y  <= v_vis ? v_nxt[YW-1:0] : '0;
            o_HSYNC       <= h_sync_act ? p_H_SYNC_POLARITY : ~p_H_SYNC_POLARITY;
            o_VSYNC       <= v_sync_act ? p_V_SYNC_POLARITY : ~p_V_SYNC_POLARITY;
        end
    end

`ifdef VGA_TIMING_FRAME_START_EN
    // Single-cycle pulse after the enabled tick that enters (0,0); held-off ticks clear it.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_FRAME_START <= 1'b0;
        end else begin
            o_FRAME_START <= i_ENABLE && (h_nxt == '0) && (v_nxt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three parameter sets run in lockstep against a position-index model.
// Frame-start checks compile in when VGA_TIMING_FRAME_START_EN is defined.
module tb_vga_timing_generator;

    localparam int TA = 800 * 525;
    localparam int TB = 7 * 6;
    localparam int TC = 32 * 19;
    localparam logic [34:0] RST_A = {1'b0, 1'b1, 1'b1, 16'd0, 16'd0};
    localparam logic [34:0] RST_C = {1'b0, 1'b0, 1'b0, 16'd0, 16'd0};

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de, b_hs, b_vs, b_de, c_hs, c_vs, c_de;
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic [1:0] b_x, b_y;
    logic [4:0] c_x;
    logic [3:0] c_y;
    logic [34:0] obs_a, obs_b, obs_c;
    assign obs_a = {a_de, a_hs, a_vs, 16'(a_x), 16'(a_y)};
    assign obs_b = {b_de, b_hs, b_vs, 16'(b_x), 16'(b_y)};
    assign obs_c = {c_de, c_hs, c_vs, 16'(c_x), 16'(c_y)};

    int n_checks = 0;
    int n_fail   = 0;
    int pos_a, pos_b, pos_c;
    logic fs_exp_b, fs_exp_c;

`ifdef VGA_TIMING_FRAME_START_EN
    logic a_fs, b_fs, c_fs;
`endif

    vga_timing_generator dut_a (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en),
        .o_HSYNC(a_hs), .o_VSYNC(a_vs), .o_DRAW_ENABLE(a_de),
        .o_SCANLINE_X(a_x), .o_SCANLINE_Y(a_y)
`ifdef VGA_TIMING_FRAME_START_EN
        , .o_FRAME_START(a_fs)
`endif
    );

    vga_timing_generator #(
        .p_H_VISIBLE_AREA(4), .p_H_FRONT_PORCH(1), .p_H_SYNC_PULSE(1), .p_H_BACK_PORCH(1),
        .p_V_VISIBLE_AREA(3), .p_V_FRONT_PORCH(1), .p_V_SYNC_PULSE(1), .p_V_BACK_PORCH(1)
    ) dut_b (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en),
        .o_HSYNC(b_hs), .o_VSYNC(b_vs), .o_DRAW_ENABLE(b_de),
        .o_SCANLINE_X(b_x), .o_SCANLINE_Y(b_y)
`ifdef VGA_TIMING_FRAME_START_EN
        , .o_FRAME_START(b_fs)
`endif
    );

    vga_timing_generator #(
        .p_H_VISIBLE_AREA(20), .p_H_FRONT_PORCH(3), .p_H_SYNC_PULSE(5), .p_H_BACK_PORCH(4),
        .p_V_VISIBLE_AREA(12), .p_V_FRONT_PORCH(2), .p_V_SYNC_PULSE(3), .p_V_BACK_PORCH(2),
        .p_H_SYNC_POLARITY(1'b1), .p_V_SYNC_POLARITY(1'b1)
    ) dut_c (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en),
        .o_HSYNC(c_hs), .o_VSYNC(c_vs), .o_DRAW_ENABLE(c_de),
        .o_SCANLINE_X(c_x), .o_SCANLINE_Y(c_y)
`ifdef VGA_TIMING_FRAME_START_EN
        , .o_FRAME_START(c_fs)
`endif
    );

    // Expected outputs for a linear raster index, derived from the phase rules.
    function automatic logic [34:0] model(int p, int hv, int hfp, int hsp, int hbp,
                                          int vv, int vfp, int vsp, int vbp, logic hp, logic vp);
        int ht, h, v;
        logic de, hs, vs;
        logic [15:0] x, y;
        ht = hv + hfp + hsp + hbp;
        h  = p % ht;
        v  = p / ht;
        de = (h < hv) && (v < vv);
        hs = (h >= hv + hfp && h < hv + hfp + hsp) ? hp : ~hp;
        vs = (v >= vv + vfp && v < vv + vfp + vsp) ? vp : ~vp;
        x  = (h < hv) ? 16'(h) : 16'd0;
        y  = (v < vv) ? 16'(v) : 16'd0;
        return {de, hs, vs, x, y};
    endfunction

    function automatic logic [34:0] ref_a(int p);
        return model(p, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction
    function automatic logic [34:0] ref_b(int p);
        return model(p, 4, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    endfunction
    function automatic logic [34:0] ref_c(int p);
        return model(p, 20, 3, 5, 4, 12, 2, 3, 2, 1'b1, 1'b1);
    endfunction

    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        if (rst) begin
            pos_a = TA - 1; pos_b = TB - 1; pos_c = TC - 1;
            fs_exp_b = 1'b0; fs_exp_c = 1'b0;
        end else if (e) begin
            pos_a = (pos_a + 1) % TA;
            pos_b = (pos_b + 1) % TB;
            pos_c = (pos_c + 1) % TC;
            fs_exp_b = (pos_b == 0);
            fs_exp_c = (pos_c == 0);
        end else begin
            fs_exp_b = 1'b0; fs_exp_c = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (obs_a !== RST_A) begin n_fail++; $display("FAIL reset_async_a act=%h exp=%h", obs_a, RST_A); end
        tick(1); tick(1); tick(0);
        n_checks++;
        if (obs_a !== RST_A) begin n_fail++; $display("FAIL reset_hold_a act=%h exp=%h", obs_a, RST_A); end
        n_checks++;
        if (obs_b !== RST_A) begin n_fail++; $display("FAIL reset_hold_b act=%h exp=%h", obs_b, RST_A); end
        n_checks++;
        if (obs_c !== RST_C) begin n_fail++; $display("FAIL reset_hold_c act=%h exp=%h", obs_c, RST_C); end
`ifdef VGA_TIMING_FRAME_START_EN
        n_checks++;
        if ({a_fs, b_fs, c_fs} !== 3'b000) begin n_fail++; $display("FAIL reset_fs act=%b exp=000", {a_fs, b_fs, c_fs}); end
`endif
        rst = 1'b0;
        tick(1);
        n_checks++;
        if ({a_de, a_x, a_y} !== {1'b1, 10'd0, 9'd0}) begin
            n_fail++; $display("FAIL first_tick_a act=%b/%0d/%0d exp=1/0/0", a_de, a_x, a_y);
        end
        n_checks++;
        if (obs_c !== ref_c(pos_c)) begin n_fail++; $display("FAIL first_tick_c act=%h exp=%h", obs_c, ref_c(pos_c)); end
`ifdef VGA_TIMING_FRAME_START_EN
        n_checks++;
        if (a_fs !== 1'b1) begin n_fail++; $display("FAIL first_tick_fs act=%b exp=1", a_fs); end
`endif
    endtask

    task automatic test_line;
        int de_cnt, hs_cnt, hs_first;
        de_cnt = a_de ? 1 : 0;
        hs_cnt = 0; hs_first = -1;
        for (int t = 1; t < 800; t++) begin
            tick(1);
            n_checks++;
            if (obs_a !== ref_a(pos_a)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL line_a pos=%0d act=%h exp=%h", pos_a, obs_a, ref_a(pos_a));
            end
            n_checks++;
            if (obs_b !== ref_b(pos_b)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL line_b pos=%0d act=%h exp=%h", pos_b, obs_b, ref_b(pos_b));
            end
            if (a_de) de_cnt++;
            if (!a_hs) begin
                if (hs_first < 0) hs_first = t;
                hs_cnt++;
            end
        end
        n_checks++;
        if (de_cnt != 640) begin n_fail++; $display("FAIL line_draw_count act=%0d exp=640", de_cnt); end
        n_checks++;
        if (hs_cnt != 96 || hs_first != 656) begin
            n_fail++; $display("FAIL line_hsync act=%0d@%0d exp=96@656", hs_cnt, hs_first);
        end
        tick(1);
        n_checks++;
        if ({a_de, a_x, a_y} !== {1'b1, 10'd0, 9'd1}) begin
            n_fail++; $display("FAIL line_wrap_a act=%b/%0d/%0d exp=1/0/1", a_de, a_x, a_y);
        end
    endtask

    task automatic test_frame;
        int vs_cnt, de_cnt;
        vs_cnt = 0; de_cnt = 0;
        for (int t = 0; t < TC; t++) begin
            tick(1);
            n_checks++;
            if (obs_c !== ref_c(pos_c)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL frame_c pos=%0d act=%h exp=%h", pos_c, obs_c, ref_c(pos_c));
            end
            n_checks++;
            if (obs_b !== ref_b(pos_b)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL frame_b pos=%0d act=%h exp=%h", pos_b, obs_b, ref_b(pos_b));
            end
            if (c_vs) vs_cnt++;
            if (c_de) de_cnt++;
        end
        n_checks++;
        if (vs_cnt != 3 * 32) begin n_fail++; $display("FAIL frame_vsync_ticks act=%0d exp=96", vs_cnt); end
        n_checks++;
        if (de_cnt != 20 * 12) begin n_fail++; $display("FAIL frame_draw_ticks act=%0d exp=240", de_cnt); end
    endtask

    task automatic test_enable_pattern;
        int de_cnt;
        de_cnt = 0;
        for (int t = 0; t < 2 * TC; t++) begin
            tick(t % 2 == 0);
            n_checks++;
            if (obs_c !== ref_c(pos_c)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL half_rate_c pos=%0d act=%h exp=%h", pos_c, obs_c, ref_c(pos_c));
            end
            n_checks++;
            if (obs_a !== ref_a(pos_a)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL half_rate_a pos=%0d act=%h exp=%h", pos_a, obs_a, ref_a(pos_a));
            end
            if (c_de) de_cnt++;
        end
        n_checks++;
        if (de_cnt != 2 * 240) begin n_fail++; $display("FAIL half_rate_draw_clocks act=%0d exp=480", de_cnt); end
    endtask

    task automatic test_random_enable;
        for (int t = 0; t < 1500; t++) begin
            tick(1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_b !== ref_b(pos_b)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_b pos=%0d act=%h exp=%h", pos_b, obs_b, ref_b(pos_b));
            end
            n_checks++;
            if (obs_c !== ref_c(pos_c)) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_c pos=%0d act=%h exp=%h", pos_c, obs_c, ref_c(pos_c));
            end
`ifdef VGA_TIMING_FRAME_START_EN
            n_checks++;
            if ({b_fs, c_fs} !== {fs_exp_b, fs_exp_c}) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rand_fs act=%b exp=%b", {b_fs, c_fs}, {fs_exp_b, fs_exp_c});
            end
`endif
        end
    endtask

    task automatic test_midframe_reset;
        int budget;
        budget = 0;
        while (pos_c != 7 * 32 + 10 && budget < 2 * TC) begin
            tick(1);
            budget++;
        end
        n_checks++;
        if (obs_c !== ref_c(7 * 32 + 10)) begin
            n_fail++; $display("FAIL midframe_position_c act=%h exp=%h", obs_c, ref_c(7 * 32 + 10));
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs_c !== RST_C) begin n_fail++; $display("FAIL midframe_async_c act=%h exp=%h", obs_c, RST_C); end
        n_checks++;
        if (obs_a !== RST_A) begin n_fail++; $display("FAIL midframe_async_a act=%h exp=%h", obs_a, RST_A); end
        tick(1); tick(0);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (obs_c !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd0}) begin
            n_fail++; $display("FAIL midframe_restart_c act=%h exp=%h", obs_c, {1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
        end
        n_checks++;
        if (obs_a !== ref_a(0)) begin n_fail++; $display("FAIL midframe_restart_a act=%h exp=%h", obs_a, ref_a(0)); end
    endtask

`ifdef VGA_TIMING_FRAME_START_EN
    task automatic test_frame_start;
        int pulses, last, budget;
        budget = 0;
        while (pos_b != TB - 1 && budget < 2 * TB) begin
            tick(1);
            budget++;
        end
        tick(1);
        n_checks++;
        if (b_fs !== 1'b1) begin n_fail++; $display("FAIL fs_enter act=%b exp=1", b_fs); end
        tick(0);
        n_checks++;
        if (b_fs !== 1'b0) begin n_fail++; $display("FAIL fs_hold_low act=%b exp=0", b_fs); end
        tick(0);
        pulses = 0; last = 0;
        for (int t = 1; t <= 3 * TB; t++) begin
            tick(1);
            n_checks++;
            if (b_fs !== fs_exp_b) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL fs_run pos=%0d act=%b exp=%b", pos_b, b_fs, fs_exp_b);
            end
            if (b_fs === 1'b1) begin
                n_checks++;
                if (t - last != TB) begin n_fail++; $display("FAIL fs_period act=%0d exp=%0d", t - last, TB); end
                last = t;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL fs_pulse_count act=%0d exp=3", pulses); end
    endtask
`endif

    initial begin
        pos_a = TA - 1; pos_b = TB - 1; pos_c = TC - 1;
        fs_exp_b = 1'b0; fs_exp_c = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_enable_pattern();
        test_random_enable();
        test_midframe_reset();
`ifdef VGA_TIMING_FRAME_START_EN
        test_frame_start();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
